// File: rtl/data_unpack_pkg.sv
// Shared constants and state encoding for the H2C unpacker and the C2H packer.
// Frames carry a SEQ_W-bit sequence number in the low bits, followed by the payload.
package data_unpack_pkg;

   localparam int unsigned BEAT_W    = 512;
   localparam int unsigned PAYLOAD_W = 4064;
   localparam int unsigned SEQ_W     = 8;

   // Number of beats needed to carry sequence number plus payload.
   function automatic int unsigned calc_nbeat(input int unsigned payload_w,
                                              input int unsigned seq_w,
                                              input int unsigned beat_w);
      return (payload_w + seq_w + beat_w - 1) / beat_w;
   endfunction

   localparam int unsigned NBEAT = calc_nbeat(PAYLOAD_W, SEQ_W, BEAT_W);

   typedef enum logic [1:0] {
      StCollect = 2'd0,
      StHold    = 2'd1,
      StDrain   = 2'd2
   } state_e;

endpackage

// File: rtl/data_unpack.sv
// Reassembles fixed-length H2C stream frames into one wide payload word, checks the
// sequence number and framing, and holds each payload until the design accepts it.
module data_unpack #(
   parameter int unsigned BEAT_W    = data_unpack_pkg::BEAT_W,
   parameter int unsigned PAYLOAD_W = data_unpack_pkg::PAYLOAD_W,
   parameter int unsigned SEQ_W     = data_unpack_pkg::SEQ_W
) (
   input  logic                 s_axis_h2c_aclk,
   input  logic                 s_axis_h2c_areset,
   input  logic [BEAT_W-1:0]    s_axis_h2c_tdata,
   input  logic                 s_axis_h2c_tvalid,
   input  logic                 s_axis_h2c_tlast,
   output logic                 s_axis_h2c_tready,
   output logic [PAYLOAD_W-1:0] in_io_data,
   output logic                 in_valid,
   input  logic                 in_ready,
   output logic                 seq_err,
   output logic                 frame_err,
   output logic [15:0]          frame_cnt
);

   import data_unpack_pkg::*;

   localparam int unsigned NumBeats = calc_nbeat(PAYLOAD_W, SEQ_W, BEAT_W);
   localparam int unsigned FrameW   = NumBeats * BEAT_W;
   localparam int unsigned UsedW    = PAYLOAD_W + SEQ_W;
   localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;

   state_e                           state_q, state_d;
   logic [NumBeats-1:0][BEAT_W-1:0]  frame_q, frame_d;
   logic [CntW-1:0]                  beat_cnt_q, beat_cnt_d;
   logic [SEQ_W-1:0]                 exp_seq_q, exp_seq_d;
   logic                             in_valid_q, in_valid_d;
   logic                             seq_err_q, seq_err_d;
   logic                             frame_err_q, frame_err_d;
   logic [15:0]                      frame_cnt_q, frame_cnt_d;

   logic [FrameW-1:0]                frame_flat;
   logic [SEQ_W-1:0]                 seq_rx;
   logic [SEQ_W-1:0]                 seq_last;
   logic                             beat_acc;
   logic                             last_slot;

   // Ready is held low through the reset cycle and while a payload is pending.
   assign s_axis_h2c_tready = ~s_axis_h2c_areset & (state_q != StHold);
   assign beat_acc          = s_axis_h2c_tvalid & s_axis_h2c_tready;
   assign last_slot         = (beat_cnt_q == CntW'(NumBeats - 1));

   assign frame_flat = frame_q;
   assign seq_rx     = frame_flat[SEQ_W-1:0];
   // With a single-beat frame the sequence number arrives on the closing beat itself.
   assign seq_last   = (beat_cnt_q == '0) ? s_axis_h2c_tdata[SEQ_W-1:0] : seq_rx;

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      beat_cnt_d  = beat_cnt_q;
      exp_seq_d   = exp_seq_q;
      in_valid_d  = in_valid_q;
      seq_err_d   = seq_err_q;
      frame_err_d = frame_err_q;
      frame_cnt_d = frame_cnt_q;

      unique case (state_q)
         StCollect: begin
            if (beat_acc) begin
               frame_d[beat_cnt_q] = s_axis_h2c_tdata;
               if (last_slot) begin
                  beat_cnt_d = '0;
                  if (s_axis_h2c_tlast) begin
                     state_d    = StHold;
                     in_valid_d = 1'b1;
                     if (seq_last != exp_seq_q) begin
                        seq_err_d = 1'b1;
                     end
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = StDrain;
                  end
               end else if (s_axis_h2c_tlast) begin
                  frame_err_d = 1'b1;
                  beat_cnt_d  = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + CntW'(1);
               end
            end
         end

         StHold: begin
            if (in_valid_q && in_ready) begin
               in_valid_d  = 1'b0;
               frame_cnt_d = frame_cnt_q + 16'd1;
               exp_seq_d   = seq_rx + SEQ_W'(1);
               state_d     = StCollect;
            end
         end

         StDrain: begin
            if (beat_acc && s_axis_h2c_tlast) begin
               beat_cnt_d = '0;
               state_d    = StCollect;
            end
         end

         default: begin
            state_d = StCollect;
         end
      endcase
   end

   always_ff @(posedge s_axis_h2c_aclk) begin
      if (s_axis_h2c_areset) begin
         state_q     <= StCollect;
         frame_q     <= '0;
         beat_cnt_q  <= '0;
         exp_seq_q   <= '0;
         in_valid_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         beat_cnt_q  <= beat_cnt_d;
         exp_seq_q   <= exp_seq_d;
         in_valid_q  <= in_valid_d;
         seq_err_q   <= seq_err_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign in_io_data = frame_flat[UsedW-1:SEQ_W];
   assign in_valid   = in_valid_q;
   assign seq_err    = seq_err_q;
   assign frame_err  = frame_err_q;
   assign frame_cnt  = frame_cnt_q;

   // Padding bits above the payload in the last beat are stored but never used.
   if (FrameW > UsedW) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^frame_flat[FrameW-1:UsedW];
   end

endmodule

// File: tb/tb_data_unpack.sv
// Directed bench for data_unpack: stimulus pushes expected payloads into a queue and a
// negedge monitor pops and compares them on every in_valid & in_ready handshake.
module tb_data_unpack;

   localparam int unsigned BW = 512;
   localparam int unsigned PW = 4064;
   localparam int unsigned SW = 8;
   localparam int unsigned FW = 4096;

   logic          clk;
   logic          areset;
   logic [BW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;
   logic [PW-1:0] in_io_data;
   logic          in_valid;
   logic          in_ready;
   logic          seq_err;
   logic          frame_err;
   logic [15:0]   frame_cnt;

   int checks = 0;
   int errors = 0;
   logic [PW-1:0] exp_q[$];

   data_unpack #(
      .BEAT_W   (BW),
      .PAYLOAD_W(PW),
      .SEQ_W    (SW)
   ) dut (
      .s_axis_h2c_aclk  (clk),
      .s_axis_h2c_areset(areset),
      .s_axis_h2c_tdata (tdata),
      .s_axis_h2c_tvalid(tvalid),
      .s_axis_h2c_tlast (tlast),
      .s_axis_h2c_tready(tready),
      .in_io_data       (in_io_data),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .seq_err          (seq_err),
      .frame_err        (frame_err),
      .frame_cnt        (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_pl(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got low64 %h expected low64 %h", name, act[63:0], exp[63:0]);
      end
   endtask

   // Frame: seq in [7:0], payload in [4071:8], all-ones padding above.
   function automatic logic [FW-1:0] mk_frame(input logic [7:0] seq, input logic [7:0] tag);
      logic [FW-1:0] f;
      for (int k = 0; k < FW / 32; k++) begin
         f[k*32 +: 32] = {tag, 8'(k), ~tag, 8'(k * 3)};
      end
      f[7:0]       = seq;
      f[FW-1:PW+SW] = '1;
      return f;
   endfunction

   function automatic logic [PW-1:0] payload_of(input logic [FW-1:0] f);
      return f[PW+SW-1:SW];
   endfunction

   // Sends nbeats beats; beat last_at carries tlast (-1 for none). Beats past 7 are filler.
   task automatic send_beats(input logic [FW-1:0] f, input int nbeats, input int last_at);
      for (int k = 0; k < nbeats; k++) begin
         int wait_cnt;
         tdata  = (k < 8) ? f[k*BW +: BW] : {16{32'hDEAD0000 + 32'(k)}};
         tvalid = 1'b1;
         tlast  = (k == last_at);
         wait_cnt = 0;
         @(negedge clk);
         while (!tready && wait_cnt < 50) begin
            wait_cnt++;
            @(negedge clk);
         end
         if (!tready) chk("tready_timeout", 64'(tready), 64'd1);
         @(posedge clk);
         #1;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic wait_sb_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      areset = 1'b1;
      @(negedge clk);
      chk("tready_in_reset", 64'(tready), 64'd0);
      @(posedge clk);
      #1;
      areset = 1'b0;
   endtask

   // Monitor: every handshake must match the oldest expected payload.
   always @(negedge clk) begin
      if (!areset && in_valid && in_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_delivery", 64'(in_valid), 64'd0);
         end else begin
            chk_pl("payload", in_io_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [FW-1:0] f;
      logic [PW-1:0] held;
      areset   = 1'b1;
      tdata    = '0;
      tvalid   = 1'b0;
      tlast    = 1'b0;
      in_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Reset state.
      @(negedge clk);
      chk("rst_in_valid", 64'(in_valid), 64'd0);
      chk("rst_in_io_data_zero", 64'(in_io_data != '0), 64'd0);
      chk("rst_seq_err", 64'(seq_err), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_tready", 64'(tready), 64'd1);
      @(posedge clk);
      #1;

      // Good frame, seq 0, in_ready high: in_valid visible right after the last beat.
      in_ready = 1'b1;
      f = mk_frame(8'h00, 8'h11);
      exp_q.push_back(payload_of(f));
      send_beats(f, 8, 7);
      @(negedge clk);
      chk("t1_in_valid_latency", 64'(in_valid), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t1_in_valid_drop", 64'(in_valid), 64'd0);
      chk("t1_seq_err", 64'(seq_err), 64'd0);
      chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);
      wait_sb_empty();

      // Back-pressure: 20 cycles held with tready low and stable payload.
      @(posedge clk);
      #1;
      in_ready = 1'b0;
      f = mk_frame(8'h01, 8'h22);
      held = payload_of(f);
      exp_q.push_back(held);
      send_beats(f, 8, 7);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t2_tready_low", 64'(tready), 64'd0);
         chk("t2_in_valid_held", 64'(in_valid), 64'd1);
         chk_pl("t2_data_stable", in_io_data, held);
         @(posedge clk);
         #1;
      end
      in_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t2_in_valid_drop", 64'(in_valid), 64'd0);
      chk("t2_frame_cnt", 64'(frame_cnt), 64'd2);
      wait_sb_empty();

      // Early tlast on beat 3: frame_err, nothing delivered, then a good seq 2 frame.
      f = mk_frame(8'h02, 8'h33);
      send_beats(f, 4, 3);
      @(negedge clk);
      chk("t4_frame_err", 64'(frame_err), 64'd1);
      chk("t4_no_valid", 64'(in_valid), 64'd0);
      @(posedge clk);
      #1;
      f = mk_frame(8'h02, 8'h44);
      exp_q.push_back(payload_of(f));
      send_beats(f, 8, 7);
      wait_sb_empty();
      @(negedge clk);
      chk("t4_frame_cnt", 64'(frame_cnt), 64'd3);
      chk("t4_seq_err", 64'(seq_err), 64'd0);
      @(posedge clk);
      #1;

      // Overlong frame: 10 beats, tlast on beat 9; beats 8-9 drained, next seq 3 delivered.
      f = mk_frame(8'h03, 8'h55);
      send_beats(f, 10, 9);
      @(negedge clk);
      chk("t5_frame_err", 64'(frame_err), 64'd1);
      chk("t5_no_valid", 64'(in_valid), 64'd0);
      chk("t5_frame_cnt_same", 64'(frame_cnt), 64'd3);
      @(posedge clk);
      #1;
      f = mk_frame(8'h03, 8'h66);
      exp_q.push_back(payload_of(f));
      send_beats(f, 8, 7);
      wait_sb_empty();
      @(negedge clk);
      chk("t5_frame_cnt", 64'(frame_cnt), 64'd4);
      chk("t5_seq_err", 64'(seq_err), 64'd0);
      @(posedge clk);
      #1;

      // Reset after beat 4: partial frame abandoned, everything cleared.
      f = mk_frame(8'h04, 8'h77);
      send_beats(f, 5, -1);
      do_reset();
      @(negedge clk);
      chk("t6_in_valid", 64'(in_valid), 64'd0);
      chk("t6_in_io_data_zero", 64'(in_io_data != '0), 64'd0);
      chk("t6_seq_err", 64'(seq_err), 64'd0);
      chk("t6_frame_err", 64'(frame_err), 64'd0);
      chk("t6_frame_cnt", 64'(frame_cnt), 64'd0);
      @(posedge clk);
      #1;
      f = mk_frame(8'h00, 8'h88);
      exp_q.push_back(payload_of(f));
      send_beats(f, 8, 7);
      wait_sb_empty();
      @(negedge clk);
      chk("t6_fresh_seq_err", 64'(seq_err), 64'd0);
      chk("t6_fresh_frame_cnt", 64'(frame_cnt), 64'd1);
      @(posedge clk);
      #1;

      // Sequence gap 0 -> 2: still delivered, seq_err sticks.
      f = mk_frame(8'h02, 8'h99);
      exp_q.push_back(payload_of(f));
      send_beats(f, 8, 7);
      wait_sb_empty();
      @(negedge clk);
      chk("t3_seq_err", 64'(seq_err), 64'd1);
      chk("t3_frame_cnt", 64'(frame_cnt), 64'd2);
      chk("t3_frame_err", 64'(frame_err), 64'd0);
      @(posedge clk);
      #1;

      // Next in-order frame (seq 3) leaves the sticky flag set.
      f = mk_frame(8'h03, 8'hAA);
      exp_q.push_back(payload_of(f));
      send_beats(f, 8, 7);
      wait_sb_empty();
      @(negedge clk);
      chk("t3_seq_err_sticky", 64'(seq_err), 64'd1);
      chk("t3_frame_cnt_3", 64'(frame_cnt), 64'd3);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
